ex_mem_skid_reg: RTL and testbench



---
 rtl/ex_mem_skid_reg_pkg.sv | 31 +++
 rtl/em_slot_reg.sv | 32 +++
 rtl/ex_mem_skid_reg.sv | 121 ++++++++++++
 tb/tb_ex_mem_skid_reg.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_skid_reg_pkg.sv
// Shared widths, op bit positions and the payload layout helper for the
// execute-to-memory boundary register.
package ex_mem_skid_reg_pkg;

  localparam int unsigned DefXlen       = 32;
  localparam int unsigned DefStoreWidth = 4;
  localparam int unsigned DefLoadWidth  = 7;
  localparam int unsigned DefRaddrW     = 5;

  // One-hot store op bit positions.
  localparam int unsigned StSb = 0;
  localparam int unsigned StSh = 1;
  localparam int unsigned StSw = 2;
  localparam int unsigned StSd = 3;

  // One-hot load op bit positions.
  localparam int unsigned LdLb  = 0;
  localparam int unsigned LdLh  = 1;
  localparam int unsigned LdLw  = 2;
  localparam int unsigned LdLd  = 3;
  localparam int unsigned LdLbu = 4;
  localparam int unsigned LdLhu = 5;
  localparam int unsigned LdLwu = 6;

  // Payload = store op, load op, valE, rs2 data, pc, rd, rd_wen, misalign bit.
  function automatic int unsigned em_payload_w(int unsigned xlen, int unsigned sw,
                                               int unsigned lw, int unsigned rw);
    return sw + lw + 3 * xlen + rw + 2;
  endfunction

endpackage

// File: rtl/em_slot_reg.sv
// One payload register with its valid bit. When en_i is high the valid bit
// takes valid_d_i; the payload is only overwritten when a valid beat lands.
module em_slot_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         valid_d_i,
  input  logic [W-1:0] data_d_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // Valid/payload state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (en_i) begin
      valid_q <= valid_d_i;
      if (valid_d_i) data_q <= data_d_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/ex_mem_skid_reg.sv
// Execute-to-memory pipeline boundary: a two-entry skid buffer (main + skid)
// with registered input ready, misalignment tagging and fire-gated store op.
module ex_mem_skid_reg
  import ex_mem_skid_reg_pkg::*;
#(
  parameter int unsigned XLEN        = DefXlen,
  parameter int unsigned STORE_WIDTH = DefStoreWidth,
  parameter int unsigned LOAD_WIDTH  = DefLoadWidth,
  parameter int unsigned RADDR_W     = DefRaddrW
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [STORE_WIDTH-1:0] E_store_op_i,
  input  logic [LOAD_WIDTH-1:0]  E_load_op_i,
  input  logic [XLEN-1:0]        E_valE_i,
  input  logic [XLEN-1:0]        E_rs2_data_i,
  input  logic [XLEN-1:0]        E_pc_i,
  input  logic [RADDR_W-1:0]     E_rd_i,
  input  logic                   E_rd_wen_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [STORE_WIDTH-1:0] ED_store_op_o,
  output logic [LOAD_WIDTH-1:0]  ED_load_op_o,
  output logic [XLEN-1:0]        ED_valE_o,
  output logic [XLEN-1:0]        ED_rs2_data_o,
  output logic [XLEN-1:0]        ED_pc_o,
  output logic [RADDR_W-1:0]     ED_rd_o,
  output logic                   ED_rd_wen_o,
  output logic                   ED_misalign_o
);

  localparam int unsigned PW    = em_payload_w(XLEN, STORE_WIDTH, LOAD_WIDTH, RADDR_W);
  localparam int unsigned OSt   = 0;
  localparam int unsigned OLd   = OSt + STORE_WIDTH;
  localparam int unsigned OVal  = OLd + LOAD_WIDTH;
  localparam int unsigned ORs2  = OVal + XLEN;
  localparam int unsigned OPc   = ORs2 + XLEN;
  localparam int unsigned ORd   = OPc + XLEN;
  localparam int unsigned OWen  = ORd + RADDR_W;
  localparam int unsigned OMis  = OWen + 1;

  logic          main_valid, skid_valid;
  logic [PW-1:0] main_data, skid_data;
  logic [PW-1:0] in_payload;
  logic          in_fire, out_fire, main_take;
  logic          main_en, main_valid_d, skid_en, skid_valid_d;
  logic [PW-1:0] main_data_d;
  logic          byte_acc, half_acc, word_acc, dword_acc, in_misalign;
  logic          head_misalign;

  // Decode access size from the one-hot ops and check the low address bits.
  always_comb begin
    byte_acc  = E_store_op_i[StSb] | E_load_op_i[LdLb] | E_load_op_i[LdLbu];
    half_acc  = E_store_op_i[StSh] | E_load_op_i[LdLh] | E_load_op_i[LdLhu];
    word_acc  = E_store_op_i[StSw] | E_load_op_i[LdLw] | E_load_op_i[LdLwu];
    dword_acc = E_store_op_i[StSd] | E_load_op_i[LdLd];
    // Byte accesses can never be misaligned; the term only guards malformed op codes.
    in_misalign = ~byte_acc & ((half_acc & E_valE_i[0]) |
                               (word_acc & (|E_valE_i[1:0])) |
                               (dword_acc & (|E_valE_i[2:0])));
  end

  assign in_payload = {in_misalign, E_rd_wen_i, E_rd_i, E_pc_i, E_rs2_data_i, E_valE_i,
                       E_load_op_i, E_store_op_i};

  assign in_ready_o = ~skid_valid & ~rst_i;
  assign in_fire    = in_valid_i & in_ready_o & ~flush_i;
  assign out_fire   = main_valid & out_ready_i;
  assign main_take  = ~main_valid | out_fire;

  // Slot enables: flush clears both; main refills from skid first to keep FIFO order.
  always_comb begin
    main_en      = flush_i | main_take;
    main_valid_d = ~flush_i & (skid_valid | in_fire);
    main_data_d  = skid_valid ? skid_data : in_payload;
    skid_en      = flush_i | (main_take & skid_valid) | (~main_take & in_fire);
    skid_valid_d = ~flush_i & ~main_take;
  end

  em_slot_reg #(
    .W(PW)
  ) u_main (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (main_en),
    .valid_d_i(main_valid_d),
    .data_d_i (main_data_d),
    .valid_o  (main_valid),
    .data_o   (main_data)
  );

  em_slot_reg #(
    .W(PW)
  ) u_skid (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (skid_en),
    .valid_d_i(skid_valid_d),
    .data_d_i (in_payload),
    .valid_o  (skid_valid),
    .data_o   (skid_data)
  );

  // Head outputs; the store op only shows on the accepting cycle so it writes once.
  always_comb begin
    head_misalign = main_data[OMis];
    out_valid_o   = main_valid;
    ED_store_op_o = (out_fire & ~head_misalign) ? main_data[OSt +: STORE_WIDTH] : '0;
    ED_load_op_o  = main_valid ? main_data[OLd +: LOAD_WIDTH] : '0;
    ED_valE_o     = main_data[OVal +: XLEN];
    ED_rs2_data_o = main_data[ORs2 +: XLEN];
    ED_pc_o       = main_data[OPc +: XLEN];
    ED_rd_o       = main_data[ORd +: RADDR_W];
    ED_rd_wen_o   = main_data[OWen] & main_valid & ~head_misalign;
    ED_misalign_o = head_misalign & main_valid;
  end

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Directed bench for ex_mem_skid_reg: streaming, backpressure, store-once,
// misalignment, flush and reset while stalled.
module tb_ex_mem_skid_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  store_op, ed_store_op;
  logic [6:0]  load_op, ed_load_op;
  logic [31:0] val_e, rs2, pc, ed_val_e, ed_rs2, ed_pc;
  logic [4:0]  rd, ed_rd;
  logic        rd_wen, ed_rd_wen, ed_misalign;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_mem_skid_reg dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .E_store_op_i (store_op),
    .E_load_op_i  (load_op),
    .E_valE_i     (val_e),
    .E_rs2_data_i (rs2),
    .E_pc_i       (pc),
    .E_rd_i       (rd),
    .E_rd_wen_i   (rd_wen),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .ED_store_op_o(ed_store_op),
    .ED_load_op_o (ed_load_op),
    .ED_valE_o    (ed_val_e),
    .ED_rs2_data_o(ed_rs2),
    .ED_pc_o      (ed_pc),
    .ED_rd_o      (ed_rd),
    .ED_rd_wen_o  (ed_rd_wen),
    .ED_misalign_o(ed_misalign)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [3:0] st, input logic [6:0] ld, input logic [31:0] v,
                      input logic [31:0] d, input logic [4:0] r, input logic w);
    in_valid = 1'b1;
    store_op = st;
    load_op  = ld;
    val_e    = v;
    rs2      = d;
    pc       = 32'h1000 + v;
    rd       = r;
    rd_wen   = w;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    store_op = '0; load_op = '0; val_e = '0; rs2 = '0; pc = '0; rd = '0; rd_wen = 1'b0;

    // Reset for two cycles.
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_store", ed_store_op, 0);

    // Stream four beats with the sink always ready.
    beat(4'b0, 7'b0, 32'h100, 32'h0, 5'd1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stream_valid", out_valid, 1);
      chk("stream_valE", ed_val_e, 32'h100 + 32'(4 * k));
      chk("stream_ready", in_ready, 1);
      chk("stream_rd_wen", ed_rd_wen, 1);
      if (k < 3) beat(4'b0, 7'b0, 32'h104 + 32'(4 * k), 32'h0, 5'(k + 2), 1'b1);
      else in_valid = 1'b0;
    end
    tick();
    chk("stream_drain", out_valid, 0);

    // Backpressure: three beats offered while the sink is stalled.
    out_ready = 1'b0;
    beat(4'b0, 7'b0, 32'h400, 32'h0, 5'd4, 1'b1);
    tick();
    chk("bp_b1_ready", in_ready, 1);
    chk("bp_b1_valE", ed_val_e, 32'h400);
    beat(4'b0, 7'b0, 32'h404, 32'h0, 5'd5, 1'b1);
    tick();
    chk("bp_b2_ready", in_ready, 0);
    chk("bp_b2_head", ed_val_e, 32'h400);
    beat(4'b0, 7'b0, 32'h408, 32'h0, 5'd6, 1'b1);
    tick();
    chk("bp_b3_stalled", in_ready, 0);
    chk("bp_b3_head", ed_val_e, 32'h400);
    out_ready = 1'b1;
    tick();
    chk("bp_rel_1", ed_val_e, 32'h404);
    chk("bp_rel_ready", in_ready, 1);
    tick();
    chk("bp_rel_2", ed_val_e, 32'h408);
    chk("bp_rel_2_valid", out_valid, 1);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", out_valid, 0);

    // Store-once: sw held for three stalled cycles, then accepted.
    out_ready = 1'b0;
    beat(4'b0100, 7'b0, 32'h200, 32'hDEADBEEF, 5'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("sw_rs2", ed_rs2, 32'hDEADBEEF);
    chk("sw_stall1", ed_store_op, 0);
    tick();
    chk("sw_stall2", ed_store_op, 0);
    tick();
    chk("sw_stall3", ed_store_op, 0);
    out_ready = 1'b1;
    #1;
    chk("sw_accept", ed_store_op, 4'b0100);
    tick();
    chk("sw_after", ed_store_op, 0);
    chk("sw_after_valid", out_valid, 0);

    // Misaligned lw: flagged, no register write.
    out_ready = 1'b0;
    beat(4'b0, 7'b0000100, 32'h202, 32'h0, 5'd3, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("lw_mis", ed_misalign, 1);
    chk("lw_rd_wen", ed_rd_wen, 0);
    chk("lw_load_op", ed_load_op, 7'b0000100);
    out_ready = 1'b1;
    tick();
    chk("lw_gone_load_op", ed_load_op, 0);

    // Misaligned sh: flagged and store suppressed on fire.
    beat(4'b0010, 7'b0, 32'h301, 32'h55, 5'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("sh_mis", ed_misalign, 1);
    chk("sh_store", ed_store_op, 0);
    tick();

    // sb at odd address: never misaligned, store fires.
    beat(4'b0001, 7'b0, 32'h303, 32'h66, 5'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("sb_mis", ed_misalign, 0);
    chk("sb_store", ed_store_op, 4'b0001);
    tick();

    // ld at 0x104 is misaligned; sd at 0x108 is aligned.
    beat(4'b0, 7'b0001000, 32'h104, 32'h0, 5'd7, 1'b1);
    tick();
    chk("ld_mis", ed_misalign, 1);
    beat(4'b1000, 7'b0, 32'h108, 32'h77, 5'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("sd_mis", ed_misalign, 0);
    chk("sd_store", ed_store_op, 4'b1000);
    tick();

    // Flush with both slots full and a beat at the input.
    out_ready = 1'b0;
    beat(4'b0100, 7'b0, 32'h500, 32'h1, 5'd0, 1'b0);
    tick();
    beat(4'b0100, 7'b0, 32'h504, 32'h2, 5'd0, 1'b0);
    tick();
    chk("fl_full", in_ready, 0);
    beat(4'b0100, 7'b0, 32'h508, 32'h3, 5'd0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    out_ready = 1'b1;
    #1;
    chk("fl_store", ed_store_op, 0);
    tick();
    chk("fl_still_empty", out_valid, 0);

    // Flush drops an incoming beat even when the buffer could take it.
    beat(4'b0, 7'b0, 32'h50C, 32'h0, 5'd1, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_drop", out_valid, 0);

    // Reset while stalled with both slots full.
    out_ready = 1'b0;
    beat(4'b0100, 7'b0, 32'h600, 32'hA, 5'd0, 1'b0);
    tick();
    beat(4'b0100, 7'b0, 32'h604, 32'hB, 5'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("mr_valid", out_valid, 0);
    chk("mr_store", ed_store_op, 0);
    chk("mr_valE", ed_val_e, 0);
    chk("mr_pc", ed_pc, 0);
    chk("mr_ready_in_rst", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("mr_ready_after", in_ready, 1);
    out_ready = 1'b1;
    beat(4'b0, 7'b0, 32'h700, 32'h0, 5'd9, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("mr_first_valid", out_valid, 1);
    chk("mr_first_valE", ed_val_e, 32'h700);
    chk("mr_first_rd", ed_rd, 5'd9);
    tick();
    chk("mr_alone", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
